trigger_unit: RTL and testbench
===============================

TRIGGER_UNIT -- requirements
Module: trigger_unit

Interface
REQ-001 Parameter NUM_TRIG, default 4, number of triggers (1..8).
REQ-002 Parameter DATA_WIDTH, default 32, CSR and address width.
REQ-003 cpu_clk  in  1  single clock; all state rises on posedge.
REQ-004 cpu_rstn  in  1  reset, asynchronous, active-low.
REQ-005 csr_addr  in  12  CSR address (tselect 0x7A0, tdata1 0x7A1, tdata2 0x7A2, tinfo 0x7A4).
REQ-006 valid_mcsr_rd / valid_mcsr_wr  in  1 each  qualified CSR read / write.
REQ-007 mcsr_set / mcsr_clr  in  1 each  set/clear write modes; both low is a plain write.
REQ-008 write_data  in  DATA_WIDTH  CSR write data.
REQ-009 read_data  out  DATA_WIDTH  CSR read data, zero unless a valid read hits a decoded address.
REQ-010 dbg_mode  in  1  core in debug mode.
REQ-011 ex_pc / ex_pc_valid  in  DATA_WIDTH / 1  executing-instruction address.
REQ-012 ls_addr / ld_valid / st_valid  in  DATA_WIDTH / 1 / 1  load/store data address.
REQ-013 trig_dbg_req  out  1  registered request to enter debug mode (action=1).
REQ-014 trig_bkpt_req  out  1  registered breakpoint-exception request (action=0).
REQ-015 trig_hit_idx  out  3  index of the firing trigger, valid with either request.

Function
REQ-016 tselect SHALL accept writes below NUM_TRIG only; otherwise it holds its value, and set/clear results are checked the same way.
REQ-017 Each trigger SHALL hold tdata1 as mcontrol: type[31:28] read-only 2, dmode[27], hit[20], action[15:12] (0 or 1 legal, else 0), chain[11], match[10:7] (0 equal, 2 >=, 3 <, else 0), m[6], execute[2], store[1], load[0]; other bits read 0.
REQ-018 tdata1/tdata2 accesses SHALL target the trigger named by tselect.
REQ-019 When selected dmode=1 and dbg_mode=0, writes to tdata1/tdata2 SHALL be ignored; dmode itself SHALL be writable only in dbg_mode.
REQ-020 tinfo SHALL read 0x0004 (mcontrol only), and writes to it SHALL be ignored.
REQ-021 Trigger i matches when m=1, dbg_mode=0, and (execute and ex_pc_valid on ex_pc) or (load and ld_valid on ls_addr) or (store and st_valid on ls_addr) satisfy match against tdata2; compares are unsigned.
REQ-022 Chain: trigger i with chain=1 SHALL fire only when i+1 also matches in the same cycle, and the chain fires as its last member; chain on trigger NUM_TRIG-1 SHALL be treated as 0.
REQ-023 Among firing triggers, the lowest index of a chain tail SHALL win.
REQ-024 Exactly one cycle after the match cycle, trig_dbg_req or trig_bkpt_req SHALL pulse for one cycle with trig_hit_idx, and the winner's hit bit SHALL be set.
REQ-025 If a CSR write to the same trigger's tdata1 occurs in the hit-set cycle, the written value SHALL take priority, including for hit.
REQ-026 Requests SHALL be suppressed when dbg_mode is high in the match cycle.
REQ-027 read_data SHALL be valid in the same cycle as valid_mcsr_rd, with no latency.

Reset
REQ-028 On cpu_rstn low, the following SHALL clear asynchronously: tselect=0, all tdata1 to 0x2000_0000, all tdata2=0, trig_dbg_req=0, trig_bkpt_req=0, trig_hit_idx=0.
REQ-029 A reset asserted mid-pulse SHALL drop the request immediately, with no replay after release.

Structure
REQ-030 CSR addresses, mcontrol field positions, and match/action encodings SHALL live in the shared dbg_defines header.
REQ-031 The per-trigger comparator SHALL be a sub-module trigger_match, instantiated NUM_TRIG times.

Verification
REQ-032 tselect=1, tdata1=0x2000_0044, tdata2=0x100; ex_pc=0x100 valid -> trig_bkpt_req pulse one cycle later, trig_hit_idx=1, tdata1[20]=1.
REQ-033 Write tselect=7 with NUM_TRIG=4 -> tselect reads back its previous value.
REQ-034 Trigger0 chain=1, match=2, tdata2=0x200, load; trigger1 match=3, tdata2=0x300, load; ld at 0x250 -> hit idx 1; ld at 0x350 -> no request.
REQ-035 Trigger0 dmode=1 action=1; write tdata2 with dbg_mode=0 -> unchanged; with dbg_mode=1 -> updated; match -> trig_dbg_req.
REQ-036 Match while dbg_mode=1 -> no request, hit bit stays 0.
REQ-037 Assert cpu_rstn low during a request pulse -> outputs 0 immediately, tdata1 reads 0x2000_0000.

Source files
------------

// File: rtl/trigger_unit_pkg.sv
// Shared debug-trigger definitions: CSR addresses, mcontrol field positions,
// match/action encodings and the tdata1 legalisation helper.
package trigger_unit_pkg;

  localparam logic [11:0] CsrTselect = 12'h7A0;
  localparam logic [11:0] CsrTdata1  = 12'h7A1;
  localparam logic [11:0] CsrTdata2  = 12'h7A2;
  localparam logic [11:0] CsrTinfo   = 12'h7A4;

  // Storage is sized for the largest supported trigger count.
  localparam int unsigned MaxTrig = 8;

  // mcontrol bit positions
  localparam int unsigned TypeLsb   = 28;
  localparam int unsigned DmodeBit  = 27;
  localparam int unsigned HitBit    = 20;
  localparam int unsigned ActionLsb = 12;
  localparam int unsigned ChainBit  = 11;
  localparam int unsigned MatchLsb  = 7;
  localparam int unsigned MBit      = 6;
  localparam int unsigned ExecBit   = 2;
  localparam int unsigned StoreBit  = 1;
  localparam int unsigned LoadBit   = 0;

  localparam logic [3:0]  TypeMcontrol = 4'd2;
  localparam logic [31:0] Tdata1Reset  = 32'h2000_0000;
  localparam logic [31:0] TinfoValue   = 32'h0000_0004;

  typedef enum logic [3:0] {
    MatchEq = 4'd0,
    MatchGe = 4'd2,
    MatchLt = 4'd3
  } match_e;

  typedef enum logic [3:0] {
    ActBkpt = 4'd0,
    ActDbg  = 4'd1
  } action_e;

  // Map a raw tdata1 write onto the supported mcontrol subset. dmode only
  // follows the write while the core is in debug mode.
  function automatic logic [31:0] mcontrol_legalize(logic [31:0] raw, logic old_dmode,
                                                     logic dbg);
    logic [31:0] v;
    logic [3:0]  act;
    logic [3:0]  mt;
    v   = '0;
    act = raw[ActionLsb +: 4];
    mt  = raw[MatchLsb +: 4];
    v[TypeLsb +: 4]   = TypeMcontrol;
    v[DmodeBit]       = dbg ? raw[DmodeBit] : old_dmode;
    v[HitBit]         = raw[HitBit];
    v[ActionLsb +: 4] = (act == ActDbg) ? ActDbg : ActBkpt;
    v[ChainBit]       = raw[ChainBit];
    v[MatchLsb +: 4]  = (mt == MatchGe || mt == MatchLt) ? mt : MatchEq;
    v[MBit]           = raw[MBit];
    v[ExecBit]        = raw[ExecBit];
    v[StoreBit]       = raw[StoreBit];
    v[LoadBit]        = raw[LoadBit];
    return v;
  endfunction

endpackage

// File: rtl/trigger_unit_if.sv
// CSR access bus between the core CSR file (master) and the trigger unit (slave).
//   csr_addr       12-bit CSR address
//   valid_mcsr_rd  qualified read; read_data returned combinationally
//   valid_mcsr_wr  qualified write
//   mcsr_set/clr   set / clear write modes (both low: plain write)
//   write_data     write data
//   read_data      read data, zero unless a valid read hits a decoded CSR
interface trigger_unit_if #(
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic [11:0]           csr_addr;
  logic                  valid_mcsr_rd;
  logic                  valid_mcsr_wr;
  logic                  mcsr_set;
  logic                  mcsr_clr;
  logic [DATA_WIDTH-1:0] write_data;
  logic [DATA_WIDTH-1:0] read_data;

  modport master (
    output csr_addr, valid_mcsr_rd, valid_mcsr_wr, mcsr_set, mcsr_clr, write_data,
    input  read_data
  );

  modport slave (
    input  csr_addr, valid_mcsr_rd, valid_mcsr_wr, mcsr_set, mcsr_clr, write_data,
    output read_data
  );

endinterface

// File: rtl/trigger_match.sv
// Per-trigger address comparator (purely combinational).
//   m_i/execute_i/store_i/load_i  mcontrol enables
//   match_mode_i                  mcontrol match field (already legalised)
//   tdata2_i                      compare value
//   dbg_mode_i                    core in debug mode (suppresses matching)
//   ex_pc_i/ex_pc_valid_i         executing instruction address
//   ls_addr_i/ld_valid_i/st_valid_i  load/store data address
//   match_o                       this trigger matches in the current cycle
module trigger_match import trigger_unit_pkg::*; #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  m_i,
  input  logic                  execute_i,
  input  logic                  store_i,
  input  logic                  load_i,
  input  logic [3:0]            match_mode_i,
  input  logic [DATA_WIDTH-1:0] tdata2_i,
  input  logic                  dbg_mode_i,
  input  logic [DATA_WIDTH-1:0] ex_pc_i,
  input  logic                  ex_pc_valid_i,
  input  logic [DATA_WIDTH-1:0] ls_addr_i,
  input  logic                  ld_valid_i,
  input  logic                  st_valid_i,
  output logic                  match_o
);

  function automatic logic addr_cmp(logic [3:0] mode, logic [DATA_WIDTH-1:0] val,
                                    logic [DATA_WIDTH-1:0] ref_val);
    case (mode)
      MatchGe: return val >= ref_val;
      MatchLt: return val < ref_val;
      default: return val == ref_val;
    endcase
  endfunction

  logic pc_hit;
  logic ls_hit;

  assign pc_hit = addr_cmp(match_mode_i, ex_pc_i, tdata2_i);
  assign ls_hit = addr_cmp(match_mode_i, ls_addr_i, tdata2_i);

  assign match_o = m_i && !dbg_mode_i &&
                   ((execute_i && ex_pc_valid_i && pc_hit) ||
                    (load_i && ld_valid_i && ls_hit) ||
                    (store_i && st_valid_i && ls_hit));

endmodule

// File: rtl/trigger_unit.sv
// Debug trigger unit: NUM_TRIG mcontrol address triggers behind tselect /
// tdata1 / tdata2 / tinfo, with chaining and a registered request pulse.
//   cpu_clk, cpu_rstn   clock, asynchronous active-low reset
//   csr                 CSR access bus (slave side)
//   dbg_mode            core in debug mode
//   ex_pc, ex_pc_valid  executing-instruction address
//   ls_addr, ld_valid, st_valid  load/store data address
//   trig_dbg_req        one-cycle request to enter debug mode (action=1)
//   trig_bkpt_req       one-cycle breakpoint exception request (action=0)
//   trig_hit_idx        index of the firing trigger, valid with a request
// DATA_WIDTH must be at least 32 (tdata1 is a 32-bit mcontrol).
module trigger_unit import trigger_unit_pkg::*; #(
  parameter int unsigned NUM_TRIG   = 4,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  cpu_clk,
  input  logic                  cpu_rstn,
  trigger_unit_if.slave         csr,
  input  logic                  dbg_mode,
  input  logic [DATA_WIDTH-1:0] ex_pc,
  input  logic                  ex_pc_valid,
  input  logic [DATA_WIDTH-1:0] ls_addr,
  input  logic                  ld_valid,
  input  logic                  st_valid,
  output logic                  trig_dbg_req,
  output logic                  trig_bkpt_req,
  output logic [2:0]            trig_hit_idx
);

  function automatic logic [DATA_WIDTH-1:0] csr_op(logic [DATA_WIDTH-1:0] cur,
                                                   logic [DATA_WIDTH-1:0] wd,
                                                   logic set, logic clr);
    if (set)      return cur | wd;
    else if (clr) return cur & ~wd;
    else          return wd;
  endfunction

  logic [2:0]            tselect_q, tselect_d;
  logic [DATA_WIDTH-1:0] tsel_new;
  logic [31:0]           tdata1_arr [MaxTrig];
  logic [DATA_WIDTH-1:0] tdata2_arr [MaxTrig];
  logic [MaxTrig-1:0]    match_vec;
  logic [MaxTrig-1:0]    fire;

  logic [31:0]           sel_tdata1;
  logic                  sel_locked;
  logic                  wr_tselect, wr_tdata1, wr_tdata2;
  logic [DATA_WIDTH-1:0] t1_raw;
  logic [31:0]           tdata1_wr_val;
  logic [DATA_WIDTH-1:0] tdata2_wr_val;

  logic                  prev_ok, prev_chain, cur_ok, cur_chain;
  logic                  fire_any;
  logic [2:0]            win_idx;
  logic                  win_action;

  logic                  dbg_req_q, dbg_req_d;
  logic                  bkpt_req_q, bkpt_req_d;
  logic [2:0]            hit_idx_q, hit_idx_d;

  // ---------------------------------------------------------------------------
  // CSR write decode
  // ---------------------------------------------------------------------------
  assign sel_tdata1 = tdata1_arr[tselect_q];
  // A debug-mode-owned trigger cannot be touched from machine mode.
  assign sel_locked = sel_tdata1[DmodeBit] && !dbg_mode;

  assign wr_tselect = csr.valid_mcsr_wr && (csr.csr_addr == CsrTselect);
  assign wr_tdata1  = csr.valid_mcsr_wr && (csr.csr_addr == CsrTdata1) && !sel_locked;
  assign wr_tdata2  = csr.valid_mcsr_wr && (csr.csr_addr == CsrTdata2) && !sel_locked;

  assign tsel_new = csr_op(DATA_WIDTH'(tselect_q), csr.write_data, csr.mcsr_set,
                           csr.mcsr_clr);
  // Out-of-range results (including set/clear results) leave tselect alone.
  assign tselect_d = (wr_tselect && (tsel_new < DATA_WIDTH'(NUM_TRIG))) ? tsel_new[2:0]
                                                                         : tselect_q;

  assign t1_raw        = csr_op(DATA_WIDTH'(sel_tdata1), csr.write_data, csr.mcsr_set,
                                csr.mcsr_clr);
  assign tdata1_wr_val = mcontrol_legalize(t1_raw[31:0], sel_tdata1[DmodeBit], dbg_mode);
  assign tdata2_wr_val = csr_op(tdata2_arr[tselect_q], csr.write_data, csr.mcsr_set,
                                csr.mcsr_clr);

  // ---------------------------------------------------------------------------
  // Per-trigger state and comparators
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < MaxTrig; i++) begin : g_trig
    if (i < NUM_TRIG) begin : g_real
      logic [31:0]           t1_q, t1_d;
      logic [DATA_WIDTH-1:0] t2_q, t2_d;
      logic                  is_sel;

      assign is_sel = (tselect_q == 3'(i));

      always_comb begin
        t1_d = t1_q;
        t2_d = t2_q;
        if (fire_any && (win_idx == 3'(i))) begin
          t1_d[HitBit] = 1'b1;
        end
        // A CSR write in the same cycle overrides the hardware hit update.
        if (wr_tdata1 && is_sel) begin
          t1_d = tdata1_wr_val;
        end
        if (wr_tdata2 && is_sel) begin
          t2_d = tdata2_wr_val;
        end
      end

      always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
          t1_q <= Tdata1Reset;
          t2_q <= '0;
        end else begin
          t1_q <= t1_d;
          t2_q <= t2_d;
        end
      end

      assign tdata1_arr[i] = t1_q;
      assign tdata2_arr[i] = t2_q;

      trigger_match #(
        .DATA_WIDTH (DATA_WIDTH)
      ) u_match (
        .m_i           (t1_q[MBit]),
        .execute_i     (t1_q[ExecBit]),
        .store_i       (t1_q[StoreBit]),
        .load_i        (t1_q[LoadBit]),
        .match_mode_i  (t1_q[MatchLsb +: 4]),
        .tdata2_i      (t2_q),
        .dbg_mode_i    (dbg_mode),
        .ex_pc_i       (ex_pc),
        .ex_pc_valid_i (ex_pc_valid),
        .ls_addr_i     (ls_addr),
        .ld_valid_i    (ld_valid),
        .st_valid_i    (st_valid),
        .match_o       (match_vec[i])
      );
    end else begin : g_absent
      assign tdata1_arr[i] = '0;
      assign tdata2_arr[i] = '0;
      assign match_vec[i]  = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Chain resolution: a chain member only counts if every earlier member of
  // the same chain matched; the chain fires at its tail (chain=0 or last).
  // ---------------------------------------------------------------------------
  always_comb begin
    fire       = '0;
    prev_ok    = 1'b1;
    prev_chain = 1'b0;
    cur_ok     = 1'b0;
    cur_chain  = 1'b0;
    for (int i = 0; i < int'(NUM_TRIG); i++) begin
      cur_ok     = match_vec[i] && (!prev_chain || prev_ok);
      cur_chain  = tdata1_arr[i][ChainBit] && (i != int'(NUM_TRIG) - 1);
      fire[i]    = cur_ok && !cur_chain;
      prev_ok    = cur_ok;
      prev_chain = cur_chain;
    end
  end

  // Lowest-index tail wins.
  always_comb begin
    win_idx  = '0;
    fire_any = 1'b0;
    for (int i = int'(NUM_TRIG) - 1; i >= 0; i--) begin
      if (fire[i]) begin
        win_idx  = 3'(i);
        fire_any = 1'b1;
      end
    end
  end

  assign win_action = tdata1_arr[win_idx][ActionLsb];

  assign dbg_req_d  = fire_any && win_action;
  assign bkpt_req_d = fire_any && !win_action;
  assign hit_idx_d  = fire_any ? win_idx : 3'd0;

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      tselect_q  <= '0;
      dbg_req_q  <= 1'b0;
      bkpt_req_q <= 1'b0;
      hit_idx_q  <= '0;
    end else begin
      tselect_q  <= tselect_d;
      dbg_req_q  <= dbg_req_d;
      bkpt_req_q <= bkpt_req_d;
      hit_idx_q  <= hit_idx_d;
    end
  end

  assign trig_dbg_req  = dbg_req_q;
  assign trig_bkpt_req = bkpt_req_q;
  assign trig_hit_idx  = hit_idx_q;

  // ---------------------------------------------------------------------------
  // CSR read (zero latency)
  // ---------------------------------------------------------------------------
  always_comb begin
    csr.read_data = '0;
    if (csr.valid_mcsr_rd) begin
      case (csr.csr_addr)
        CsrTselect: csr.read_data = DATA_WIDTH'(tselect_q);
        CsrTdata1:  csr.read_data = DATA_WIDTH'(sel_tdata1);
        CsrTdata2:  csr.read_data = tdata2_arr[tselect_q];
        CsrTinfo:   csr.read_data = DATA_WIDTH'(TinfoValue);
        default:    csr.read_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_trigger_unit.sv
// Directed bench for trigger_unit: a CSR access table followed by hand-written
// match / chain / debug-mode / reset sequences.
module tb_trigger_unit;

  localparam logic [11:0] A_TSEL = 12'h7A0;
  localparam logic [11:0] A_TD1  = 12'h7A1;
  localparam logic [11:0] A_TD2  = 12'h7A2;
  localparam logic [11:0] A_TINF = 12'h7A4;

  logic        cpu_clk;
  logic        cpu_rstn;
  logic        dbg_mode;
  logic [31:0] ex_pc;
  logic        ex_pc_valid;
  logic [31:0] ls_addr;
  logic        ld_valid;
  logic        st_valid;
  logic        trig_dbg_req;
  logic        trig_bkpt_req;
  logic [2:0]  trig_hit_idx;

  int n_cmp;
  int n_fail;

  trigger_unit_if #(.DATA_WIDTH(32)) csr_bus ();

  trigger_unit #(
    .NUM_TRIG   (4),
    .DATA_WIDTH (32)
  ) dut (
    .cpu_clk       (cpu_clk),
    .cpu_rstn      (cpu_rstn),
    .csr           (csr_bus),
    .dbg_mode      (dbg_mode),
    .ex_pc         (ex_pc),
    .ex_pc_valid   (ex_pc_valid),
    .ls_addr       (ls_addr),
    .ld_valid      (ld_valid),
    .st_valid      (st_valid),
    .trig_dbg_req  (trig_dbg_req),
    .trig_bkpt_req (trig_bkpt_req),
    .trig_hit_idx  (trig_hit_idx)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  typedef struct {
    string       name;
    logic        is_rd;
    logic [11:0] addr;
    logic [31:0] data;   // write data, or expected read data
    logic        set;
    logic        clr;
    logic        dbg;
  } csr_vec_t;

  csr_vec_t vecs[$];

  function automatic csr_vec_t mk(string n, logic rd, logic [11:0] a, logic [31:0] d,
                                  logic s, logic c, logic dbg);
    csr_vec_t v;
    v.name = n; v.is_rd = rd; v.addr = a; v.data = d; v.set = s; v.clr = c; v.dbg = dbg;
    return v;
  endfunction

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", n, got, exp);
    end
  endtask

  // Entered and left at a negedge.
  task automatic csr_wr(input logic [11:0] a, input logic [31:0] d, input logic s,
                        input logic c, input logic dbg);
    dbg_mode              = dbg;
    csr_bus.csr_addr      = a;
    csr_bus.write_data    = d;
    csr_bus.mcsr_set      = s;
    csr_bus.mcsr_clr      = c;
    csr_bus.valid_mcsr_wr = 1'b1;
    @(negedge cpu_clk);
    csr_bus.valid_mcsr_wr = 1'b0;
    csr_bus.mcsr_set      = 1'b0;
    csr_bus.mcsr_clr      = 1'b0;
    dbg_mode              = 1'b0;
  endtask

  task automatic csr_rd(input string n, input logic [11:0] a, input logic [31:0] e);
    csr_bus.csr_addr      = a;
    csr_bus.valid_mcsr_rd = 1'b1;
    #1;
    chk(n, csr_bus.read_data, e);
    csr_bus.valid_mcsr_rd = 1'b0;
    @(negedge cpu_clk);
  endtask

  // One cycle of address stimulus, then check the pulse and its end.
  task automatic stim(input string n, input logic exv, input logic [31:0] pc,
                      input logic ld, input logic st, input logic [31:0] la,
                      input logic edbg, input logic ebk, input logic [2:0] eidx);
    ex_pc_valid = exv; ex_pc = pc; ld_valid = ld; st_valid = st; ls_addr = la;
    @(posedge cpu_clk); #1;
    chk({n, " dbg_req"}, 32'(trig_dbg_req), 32'(edbg));
    chk({n, " bkpt_req"}, 32'(trig_bkpt_req), 32'(ebk));
    if (edbg || ebk) chk({n, " hit_idx"}, 32'(trig_hit_idx), 32'(eidx));
    @(negedge cpu_clk);
    ex_pc_valid = 1'b0; ld_valid = 1'b0; st_valid = 1'b0;
    @(posedge cpu_clk); #1;
    chk({n, " pulse end"}, 32'({trig_dbg_req, trig_bkpt_req}), 32'd0);
    @(negedge cpu_clk);
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    cpu_rstn = 1'b0; dbg_mode = 1'b0;
    ex_pc = '0; ex_pc_valid = 1'b0; ls_addr = '0; ld_valid = 1'b0; st_valid = 1'b0;
    csr_bus.csr_addr = '0; csr_bus.valid_mcsr_rd = 1'b0; csr_bus.valid_mcsr_wr = 1'b0;
    csr_bus.mcsr_set = 1'b0; csr_bus.mcsr_clr = 1'b0; csr_bus.write_data = '0;

    #1;
    chk("reset outputs", 32'({trig_dbg_req, trig_bkpt_req, trig_hit_idx}), 32'd0);
    repeat (2) @(negedge cpu_clk);
    cpu_rstn = 1'b1;
    @(negedge cpu_clk);

    // ---- CSR table ------------------------------------------------------
    vecs.push_back(mk("rst tselect",    1, A_TSEL, 32'h0,          0, 0, 0));
    vecs.push_back(mk("rst tdata1",     1, A_TD1,  32'h2000_0000,  0, 0, 0));
    vecs.push_back(mk("rst tdata2",     1, A_TD2,  32'h0,          0, 0, 0));
    vecs.push_back(mk("",               0, A_TSEL, 32'd1,          0, 0, 0));
    vecs.push_back(mk("tselect=1",      1, A_TSEL, 32'd1,          0, 0, 0));
    vecs.push_back(mk("",               0, A_TSEL, 32'd7,          0, 0, 0));
    vecs.push_back(mk("tselect 7 rej",  1, A_TSEL, 32'd1,          0, 0, 0));
    vecs.push_back(mk("",               0, A_TSEL, 32'd2,          1, 0, 0));
    vecs.push_back(mk("tselect set",    1, A_TSEL, 32'd3,          0, 0, 0));
    vecs.push_back(mk("",               0, A_TSEL, 32'd4,          1, 0, 0));
    vecs.push_back(mk("tselect set rej",1, A_TSEL, 32'd3,          0, 0, 0));
    vecs.push_back(mk("",               0, A_TSEL, 32'd1,          0, 1, 0));
    vecs.push_back(mk("tselect clr",    1, A_TSEL, 32'd2,          0, 0, 0));
    vecs.push_back(mk("",               0, A_TD1,  32'hFFFF_FFFF,  0, 0, 0));
    vecs.push_back(mk("tdata1 legal",   1, A_TD1,  32'h2010_0847,  0, 0, 0));
    vecs.push_back(mk("",               0, A_TD1,  32'h0000_11C4,  0, 0, 0));
    vecs.push_back(mk("tdata1 act/mt",  1, A_TD1,  32'h2000_11C4,  0, 0, 0));
    vecs.push_back(mk("",               0, A_TD1,  32'h0000_0040,  0, 1, 0));
    vecs.push_back(mk("tdata1 clr",     1, A_TD1,  32'h2000_1184,  0, 0, 0));
    vecs.push_back(mk("",               0, A_TD2,  32'hDEAD_BEEF,  0, 0, 0));
    vecs.push_back(mk("tdata2 wr",      1, A_TD2,  32'hDEAD_BEEF,  0, 0, 0));
    vecs.push_back(mk("undecoded addr", 1, 12'h7A3,32'h0,          0, 0, 0));
    vecs.push_back(mk("tinfo",          1, A_TINF, 32'h4,          0, 0, 0));
    vecs.push_back(mk("",               0, A_TINF, 32'hFFFF_FFFF,  0, 0, 0));
    vecs.push_back(mk("tinfo ro",       1, A_TINF, 32'h4,          0, 0, 0));
    vecs.push_back(mk("",               0, A_TSEL, 32'd0,          0, 0, 0));
    vecs.push_back(mk("trig0 separate", 1, A_TD1,  32'h2000_0000,  0, 0, 0));
    vecs.push_back(mk("",               0, A_TD1,  32'h0800_0000,  0, 0, 0));
    vecs.push_back(mk("dmode m-mode",   1, A_TD1,  32'h2000_0000,  0, 0, 0));
    vecs.push_back(mk("",               0, A_TD1,  32'h0000_2000,  1, 0, 0));
    vecs.push_back(mk("action illegal", 1, A_TD1,  32'h2000_0000,  0, 0, 0));
    vecs.push_back(mk("",               0, A_TD1,  32'h0000_00C0,  0, 0, 0));
    vecs.push_back(mk("match illegal",  1, A_TD1,  32'h2000_0040,  0, 0, 0));
    vecs.push_back(mk("",               0, A_TD1,  32'h0000_0000,  0, 0, 0));

    foreach (vecs[k]) begin
      if (vecs[k].is_rd) csr_rd(vecs[k].name, vecs[k].addr, vecs[k].data);
      else csr_wr(vecs[k].addr, vecs[k].data, vecs[k].set, vecs[k].clr, vecs[k].dbg);
    end

    // ---- Execute match on trigger 1 -------------------------------------
    csr_wr(A_TSEL, 32'd1, 0, 0, 0);
    csr_wr(A_TD1, 32'h2000_0044, 0, 0, 0);
    csr_wr(A_TD2, 32'h0000_0100, 0, 0, 0);
    stim("exec t1", 1, 32'h100, 0, 0, 32'h0, 0, 1, 3'd1);
    csr_rd("t1 hit set", A_TD1, 32'h2010_0044);
    csr_bus.csr_addr = A_TD2; csr_bus.valid_mcsr_rd = 1'b0;
    #1;
    chk("read not valid", csr_bus.read_data, 32'h0);
    @(negedge cpu_clk);

    // ---- CSR write wins over hit in the same cycle ----------------------
    csr_wr(A_TD1, 32'h2000_0044, 0, 0, 0);
    ex_pc = 32'h100; ex_pc_valid = 1'b1;
    csr_bus.csr_addr = A_TD1; csr_bus.write_data = 32'h2000_0044;
    csr_bus.valid_mcsr_wr = 1'b1;
    @(posedge cpu_clk); #1;
    chk("wr-vs-hit bkpt", 32'(trig_bkpt_req), 32'd1);
    @(negedge cpu_clk);
    csr_bus.valid_mcsr_wr = 1'b0; ex_pc_valid = 1'b0;
    csr_rd("wr-vs-hit tdata1", A_TD1, 32'h2000_0044);

    // ---- Chain t0 (>=0x200) -> t1 (<0x300), loads -----------------------
    csr_wr(A_TSEL, 32'd0, 0, 0, 0);
    csr_wr(A_TD1, 32'h0000_0941, 0, 0, 0);
    csr_wr(A_TD2, 32'h0000_0200, 0, 0, 0);
    csr_wr(A_TSEL, 32'd1, 0, 0, 0);
    csr_wr(A_TD1, 32'h0000_01C1, 0, 0, 0);
    csr_wr(A_TD2, 32'h0000_0300, 0, 0, 0);
    stim("chain ld 0x250", 0, 32'h0, 1, 0, 32'h250, 0, 1, 3'd1);
    stim("chain ld 0x350", 0, 32'h0, 1, 0, 32'h350, 0, 0, 3'd0);
    stim("chain ld 0x150", 0, 32'h0, 1, 0, 32'h150, 0, 0, 3'd0);
    csr_rd("chain tail hit", A_TD1, 32'h2010_01C1);
    csr_wr(A_TSEL, 32'd0, 0, 0, 0);
    csr_rd("chain head no hit", A_TD1, 32'h2000_0941);

    // ---- dmode protection and debug action on trigger 0 -----------------
    csr_wr(A_TD1, 32'h0800_1044, 0, 0, 1);
    csr_rd("dmode set in dbg", A_TD1, 32'h2800_1044);
    csr_wr(A_TD2, 32'h0000_0400, 0, 0, 0);
    csr_rd("tdata2 locked", A_TD2, 32'h0000_0200);
    csr_wr(A_TD1, 32'h0000_0000, 0, 0, 0);
    csr_rd("tdata1 locked", A_TD1, 32'h2800_1044);
    csr_wr(A_TD2, 32'h0000_0400, 0, 0, 1);
    csr_rd("tdata2 dbg wr", A_TD2, 32'h0000_0400);
    stim("dmode exec", 1, 32'h400, 0, 0, 32'h0, 1, 0, 3'd0);

    // ---- No request while in debug mode --------------------------------
    csr_wr(A_TD1, 32'h0800_1044, 0, 0, 1);
    dbg_mode = 1'b1;
    stim("in dbg_mode", 1, 32'h400, 0, 0, 32'h0, 0, 0, 3'd0);
    dbg_mode = 1'b0;
    csr_rd("dbg hit clear", A_TD1, 32'h2800_1044);

    // ---- Reset in the middle of a pulse ---------------------------------
    ex_pc = 32'h400; ex_pc_valid = 1'b1;
    @(posedge cpu_clk); #1;
    chk("pre-reset dbg_req", 32'(trig_dbg_req), 32'd1);
    #2;
    cpu_rstn = 1'b0;
    #1;
    chk("reset drops req",
        32'({trig_dbg_req, trig_bkpt_req, trig_hit_idx}), 32'd0);
    ex_pc_valid = 1'b0;
    csr_rd("reset tdata1", A_TD1, 32'h2000_0000);
    cpu_rstn = 1'b1;
    @(posedge cpu_clk); #1;
    chk("no replay", 32'({trig_dbg_req, trig_bkpt_req}), 32'd0);
    @(negedge cpu_clk);

    // ---- Two independent triggers fire together: lowest wins -----------
    csr_wr(A_TSEL, 32'd2, 0, 0, 0);
    csr_wr(A_TD1, 32'h0000_0044, 0, 0, 0);
    csr_wr(A_TD2, 32'h0000_0500, 0, 0, 0);
    csr_wr(A_TSEL, 32'd3, 0, 0, 0);
    csr_wr(A_TD1, 32'h0000_0044, 0, 0, 0);
    csr_wr(A_TD2, 32'h0000_0500, 0, 0, 0);
    stim("priority", 1, 32'h500, 0, 0, 32'h0, 0, 1, 3'd2);
    csr_rd("loser no hit", A_TD1, 32'h2000_0044);
    csr_wr(A_TSEL, 32'd2, 0, 0, 0);
    csr_rd("winner hit", A_TD1, 32'h2010_0044);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
